// File: rtl/dog_pkg.sv
// Shared types for the dog scene controller.
//   coord_t      : 10-bit unsigned screen coordinate
//   dog_state_e  : sequencer states
//   FR_*         : sprite frame codes driven on dog_frame
package dog_pkg;

    typedef logic [9:0] coord_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WALK   = 3'd1,
        SNIFF  = 3'd2,
        JUMP   = 3'd3,
        HIDDEN = 3'd4,
        POPUP  = 3'd5,
        HOLD   = 3'd6,
        DROP   = 3'd7
    } dog_state_e;

    // Codes 0-3 are the walk cycle; only the base code is named.
    localparam logic [2:0] FR_WALK0 = 3'd0;
    localparam logic [2:0] FR_SNIFF = 3'd4;
    localparam logic [2:0] FR_JUMP  = 3'd5;
    localparam logic [2:0] FR_DUCK  = 3'd6;
    localparam logic [2:0] FR_LAUGH = 3'd7;

endpackage

// File: rtl/dog_sequencer_frame_tick_gen.sv
// Rising-edge detector for the frame clock.
//   Clk       : system clock
//   Reset     : asynchronous active-high reset
//   frame_clk : frame clock level, sampled in the Clk domain
//   tick      : one-Clk pulse per frame_clk rising edge (registered)
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic frame_clk_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_clk_q <= 1'b0;
            tick        <= 1'b0;
        end else begin
            frame_clk_q <= frame_clk;
            tick        <= frame_clk & ~frame_clk_q;
        end
    end

endmodule

// File: rtl/dog_sequencer.sv
// Dog sprite scene controller: walk / sniff / jump intro and result pop-up.
//   Clk, Reset   : system clock, asynchronous active-high reset
//   frame_clk    : ~60 Hz frame clock level; motion advances once per rising edge
//   start_round  : one-Clk request, accepted only in IDLE
//   show_result  : one-Clk request, accepted only in HIDDEN; hit sampled with it
//   dog_x, dog_y : sprite top-left position
//   dog_frame    : sprite frame code (see dog_pkg)
//   dog_visible  : renderer enable
//   busy         : high in every state except IDLE
//   round_ready  : high while the dog is hidden in the grass
//   result_done  : one-Clk pulse when the pop-up has dropped back out of view
//   state_dbg    : current sequencer state
// Handshake: start_round/show_result are single-Clk pulses with no ready;
// a pulse is consumed if it lands in the accepting state and dropped otherwise.
module dog_sequencer
    import dog_pkg::*;
#(
    parameter coord_t     X_START      = 10'd1,
    parameter coord_t     X_JUMP       = 10'd256,
    parameter coord_t     Y_GROUND     = 10'd240,
    parameter coord_t     Y_HIDE       = 10'd300,
    parameter coord_t     Y_POP        = 10'd260,
    parameter coord_t     WALK_STEP    = 10'd1,
    parameter logic [7:0] ANIM_DIV     = 8'd10,
    parameter logic [7:0] SNIFF_FRAMES = 8'd60,
    parameter logic [7:0] JUMP_RISE    = 8'd32,
    parameter logic [7:0] HOLD_FRAMES  = 8'd90
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       start_round,
    input  logic       show_result,
    input  logic       hit,
    output coord_t     dog_x,
    output coord_t     dog_y,
    output logic [2:0] dog_frame,
    output logic       dog_visible,
    output logic       busy,
    output logic       round_ready,
    output logic       result_done,
    output dog_state_e state_dbg
);

    logic       tick;
    dog_state_e state, state_n;
    coord_t     x_n, y_n;
    logic [2:0] frame_n;
    logic       vis_n, done_n;
    logic [7:0] cnt, cnt_n;
    logic [7:0] anim_cnt, anim_n;
    coord_t     x_step, y_up1, y_up2, y_dn1, y_dn2;

    frame_tick_gen u_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    assign x_step = dog_x + WALK_STEP;
    assign y_up1  = dog_y - 10'd1;
    assign y_up2  = dog_y - 10'd2;
    assign y_dn1  = dog_y + 10'd1;
    assign y_dn2  = dog_y + 10'd2;

    assign busy        = (state != IDLE);
    assign round_ready = (state == HIDDEN);
    assign state_dbg   = state;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            dog_x       <= X_START;
            dog_y       <= Y_GROUND;
            dog_frame   <= FR_WALK0;
            dog_visible <= 1'b0;
            result_done <= 1'b0;
            cnt         <= 8'd0;
            anim_cnt    <= 8'd0;
        end else begin
            state       <= state_n;
            dog_x       <= x_n;
            dog_y       <= y_n;
            dog_frame   <= frame_n;
            dog_visible <= vis_n;
            result_done <= done_n;
            cnt         <= cnt_n;
            anim_cnt    <= anim_n;
        end
    end

    // Request-driven transitions ignore tick, so a request coinciding with
    // a tick changes state without moving the dog on that cycle.
    always_comb begin
        state_n = state;
        x_n     = dog_x;
        y_n     = dog_y;
        frame_n = dog_frame;
        vis_n   = dog_visible;
        done_n  = 1'b0;
        cnt_n   = cnt;
        anim_n  = anim_cnt;

        case (state)
            IDLE: begin
                vis_n   = 1'b1;
                frame_n = FR_WALK0;
                if (start_round) begin
                    state_n = WALK;
                    cnt_n   = 8'd0;
                    anim_n  = 8'd0;
                end
            end
            WALK: if (tick) begin
                if (x_step >= X_JUMP) begin
                    x_n     = X_JUMP;
                    frame_n = FR_SNIFF;
                    state_n = SNIFF;
                    cnt_n   = 8'd0;
                    anim_n  = 8'd0;
                end else begin
                    x_n = x_step;
                    if (anim_cnt == ANIM_DIV - 8'd1) begin
                        anim_n  = 8'd0;
                        frame_n = {1'b0, dog_frame[1:0] + 2'd1};
                    end else begin
                        anim_n = anim_cnt + 8'd1;
                    end
                end
            end
            SNIFF: if (tick) begin
                if (cnt == SNIFF_FRAMES - 8'd1) begin
                    frame_n = FR_JUMP;
                    state_n = JUMP;
                    cnt_n   = 8'd0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            // cnt stops at JUMP_RISE so the fall phase cannot wrap it.
            JUMP: if (tick) begin
                if (cnt < JUMP_RISE) begin
                    y_n   = y_up2;
                    cnt_n = cnt + 8'd1;
                end else if (y_dn2 >= Y_HIDE) begin
                    y_n     = Y_HIDE;
                    vis_n   = 1'b0;
                    state_n = HIDDEN;
                    cnt_n   = 8'd0;
                end else begin
                    y_n = y_dn2;
                end
            end
            HIDDEN: if (show_result) begin
                frame_n = hit ? FR_DUCK : FR_LAUGH;
                vis_n   = 1'b1;
                state_n = POPUP;
                cnt_n   = 8'd0;
            end
            POPUP: if (tick) begin
                y_n = y_up1;
                if (y_up1 <= Y_POP) begin
                    state_n = HOLD;
                    cnt_n   = 8'd0;
                end
            end
            HOLD: if (tick) begin
                if (cnt == HOLD_FRAMES - 8'd1) begin
                    state_n = DROP;
                    cnt_n   = 8'd0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            DROP: if (tick) begin
                if (y_dn1 >= Y_HIDE) begin
                    done_n  = 1'b1;
                    x_n     = X_START;
                    y_n     = Y_GROUND;
                    frame_n = FR_WALK0;
                    vis_n   = 1'b1;
                    state_n = IDLE;
                    cnt_n   = 8'd0;
                    anim_n  = 8'd0;
                end else begin
                    y_n = y_dn1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dog_sequencer.sv
module tb_dog_sequencer;
    import dog_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_clk = 1'b0;
    logic       start_round = 1'b0;
    logic       show_result = 1'b0;
    logic       hit = 1'b0;
    coord_t     dog_x, dog_y;
    logic [2:0] dog_frame;
    logic       dog_visible, busy, round_ready, result_done;
    dog_state_e state_dbg;

    int total = 0;
    int bad = 0;
    int rd_count = 0;

    dog_sequencer #(
        .X_JUMP       (10'd9),
        .ANIM_DIV     (8'd2),
        .SNIFF_FRAMES (8'd3),
        .JUMP_RISE    (8'd4),
        .HOLD_FRAMES  (8'd2)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .start_round (start_round),
        .show_result (show_result),
        .hit         (hit),
        .dog_x       (dog_x),
        .dog_y       (dog_y),
        .dog_frame   (dog_frame),
        .dog_visible (dog_visible),
        .busy        (busy),
        .round_ready (round_ready),
        .result_done (result_done),
        .state_dbg   (state_dbg)
    );

    // clock / reset-independent monitors
    always #5 Clk = ~Clk;

    always @(negedge Clk) if (result_done) rd_count++;

    typedef struct {
        int         ticks;
        dog_state_e st;
        int         x;
        int         y;
        int         fr;
        int         vis;
        int         rdy;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input dog_state_e st, input int x, input int y,
                             input int fr, input int vis, input int rdy);
        check($sformatf("%s.state", tag), int'(state_dbg), int'(st));
        check($sformatf("%s.x", tag), int'(dog_x), x);
        check($sformatf("%s.y", tag), int'(dog_y), y);
        check($sformatf("%s.frame", tag), int'(dog_frame), fr);
        check($sformatf("%s.vis", tag), int'(dog_visible), vis);
        check($sformatf("%s.ready", tag), int'(round_ready), rdy);
        check($sformatf("%s.busy", tag), int'(busy), (st != IDLE) ? 1 : 0);
    endtask

    // driver tasks: all inputs change on the falling edge
    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_clk = 1'b1;
            repeat (2) @(negedge Clk);
            frame_clk = 1'b0;
            repeat (2) @(negedge Clk);
        end
    endtask

    task automatic pulse_start();
        start_round = 1'b1;
        @(negedge Clk);
        start_round = 1'b0;
        @(negedge Clk);
    endtask

    task automatic pulse_result(input logic h);
        hit = h;
        show_result = 1'b1;
        @(negedge Clk);
        show_result = 1'b0;
        hit = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        tbl[0]  = '{1, WALK,   2, 240, 0, 1, 0};
        tbl[1]  = '{1, WALK,   3, 240, 1, 1, 0};
        tbl[2]  = '{1, WALK,   4, 240, 1, 1, 0};
        tbl[3]  = '{1, WALK,   5, 240, 2, 1, 0};
        tbl[4]  = '{1, WALK,   6, 240, 2, 1, 0};
        tbl[5]  = '{1, WALK,   7, 240, 3, 1, 0};
        tbl[6]  = '{1, WALK,   8, 240, 3, 1, 0};
        tbl[7]  = '{1, SNIFF,  9, 240, 4, 1, 0};
        tbl[8]  = '{2, SNIFF,  9, 240, 4, 1, 0};
        tbl[9]  = '{1, JUMP,   9, 240, 5, 1, 0};
        tbl[10] = '{1, JUMP,   9, 238, 5, 1, 0};
        tbl[11] = '{3, JUMP,   9, 232, 5, 1, 0};
        tbl[12] = '{1, JUMP,   9, 234, 5, 1, 0};
        tbl[13] = '{32, JUMP,  9, 298, 5, 1, 0};
        tbl[14] = '{1, HIDDEN, 9, 300, 5, 0, 1};

        // reset values, checked while reset is asserted
        #1 Reset = 1'b1;
        #2;
        check_all("reset", IDLE, 1, 240, 0, 0, 0);
        check("reset.done", int'(result_done), 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check_all("idle", IDLE, 1, 240, 0, 1, 0);

        // round 1 intro, table driven
        pulse_start();
        check_all("start", WALK, 1, 240, 0, 1, 0);
        for (int i = 0; i < 15; i++) begin
            do_ticks(tbl[i].ticks);
            check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].x, tbl[i].y,
                      tbl[i].fr, tbl[i].vis, tbl[i].rdy);
        end

        // start_round is dropped while hidden; ticks do not move the dog
        pulse_start();
        do_ticks(2);
        check_all("hidden_start", HIDDEN, 9, 300, 5, 0, 1);

        // miss result: laugh pop-up, hold, drop, single done pulse
        pulse_result(1'b0);
        check_all("popup", POPUP, 9, 300, 7, 1, 0);
        do_ticks(39);
        check_all("popup39", POPUP, 9, 261, 7, 1, 0);
        do_ticks(1);
        check_all("hold", HOLD, 9, 260, 7, 1, 0);
        do_ticks(1);
        check_all("hold1", HOLD, 9, 260, 7, 1, 0);
        do_ticks(1);
        check_all("drop", DROP, 9, 260, 7, 1, 0);
        do_ticks(39);
        check_all("drop39", DROP, 9, 299, 7, 1, 0);
        check("drop39.done_cnt", rd_count, 0);
        do_ticks(1);
        repeat (4) @(negedge Clk);
        check_all("end", IDLE, 1, 240, 0, 1, 0);
        check("end.done_cnt", rd_count, 1);

        // round 2: start_round on the same Clk as a tick -> no motion
        frame_clk = 1'b1;
        @(negedge Clk);
        start_round = 1'b1;
        @(negedge Clk);
        start_round = 1'b0;
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
        check_all("start_tick", WALK, 1, 240, 0, 1, 0);

        // show_result while walking is dropped
        pulse_result(1'b1);
        check_all("walk_result", WALK, 1, 240, 0, 1, 0);

        // frame_clk held high for 1000 Clk -> a single step
        frame_clk = 1'b1;
        repeat (1000) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
        check_all("held_high", WALK, 2, 240, 0, 1, 0);

        do_ticks(7);
        check_all("r2_sniff", SNIFF, 9, 240, 4, 1, 0);
        do_ticks(3);
        check_all("r2_jump", JUMP, 9, 240, 5, 1, 0);
        do_ticks(38);
        check_all("r2_hidden", HIDDEN, 9, 300, 5, 0, 1);

        // hit result: duck frame
        pulse_result(1'b1);
        check_all("r2_popup", POPUP, 9, 300, 6, 1, 0);
        do_ticks(5);
        check_all("r2_popup5", POPUP, 9, 295, 6, 1, 0);

        // async reset mid pop-up, observed before any Clk edge
        #2 Reset = 1'b1;
        #1;
        check_all("mid_reset", IDLE, 1, 240, 0, 0, 0);
        check("mid_reset.done", int'(result_done), 0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (4) @(negedge Clk);
        check_all("after_reset", IDLE, 1, 240, 0, 1, 0);
        check("after_reset.done_cnt", rd_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
